// File: rtl/bldc_pkg.sv
// Shared definitions for the six-step BLDC commutator: FSM states, step codes,
// bridge gate patterns ordered {u_up,u_down,v_up,v_down,w_up,w_down}.
package bldc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam logic [2:0] STEP_IDLE = 3'd0;
    localparam logic [2:0] STEP_1    = 3'd1;
    localparam logic [2:0] STEP_2    = 3'd2;
    localparam logic [2:0] STEP_3    = 3'd3;
    localparam logic [2:0] STEP_4    = 3'd4;
    localparam logic [2:0] STEP_5    = 3'd5;
    localparam logic [2:0] STEP_6    = 3'd6;

    localparam logic [5:0] GATES_OFF = 6'b000000;
    localparam logic [5:0] GATES_S1  = 6'b100001;  // u_up / w_down
    localparam logic [5:0] GATES_S2  = 6'b100100;  // u_up / v_down
    localparam logic [5:0] GATES_S3  = 6'b000110;  // w_up / v_down
    localparam logic [5:0] GATES_S4  = 6'b010010;  // w_up / u_down
    localparam logic [5:0] GATES_S5  = 6'b011000;  // v_up / u_down
    localparam logic [5:0] GATES_S6  = 6'b001001;  // v_up / w_down

    // Bits that are high-side switches and therefore PWM-gated.
    localparam logic [5:0] HIGH_MASK = 6'b101010;

    function automatic logic [5:0] gate_pattern(input logic [2:0] s);
        logic [5:0] p;
        case (s)
            STEP_1:  p = GATES_S1;
            STEP_2:  p = GATES_S2;
            STEP_3:  p = GATES_S3;
            STEP_4:  p = GATES_S4;
            STEP_5:  p = GATES_S5;
            STEP_6:  p = GATES_S6;
            default: p = GATES_OFF;
        endcase
        return p;
    endfunction

    function automatic logic [2:0] next_step(input logic [2:0] s, input logic rev);
        logic [2:0] n;
        if (!rev) begin
            n = (s == STEP_6) ? STEP_1 : s + 3'd1;
        end else begin
            n = (s == STEP_1) ? STEP_6 : s - 3'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bldc_pwm_gen.sv
// Free-running PWM_W-bit counter with duty compare; pwm_on is high while the
// counter is below duty, so duty=0 never fires and max duty misses one slot.
module bldc_pwm_gen #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm_on
);

    logic [PWM_W-1:0] pwm_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_reg <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + PWM_W'(1);
        end
    end

    assign pwm_on = (pwm_cnt_reg < duty);

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation engine with registered gate drives.
// Optional dead time between steps: define BLDC_COMMUTATOR_DEADTIME_EN.
module bldc_commutator
    import bldc_pkg::*;
#(
    parameter int PER_W    = 32,
    parameter int PWM_W    = 8,
    parameter int DEAD_CYC = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    input  logic [PER_W-1:0] step_period,
    input  logic [PWM_W-1:0] duty,
    output logic             u_up,
    output logic             u_down,
    output logic             v_up,
    output logic             v_down,
    output logic             w_up,
    output logic             w_down,
    output logic [2:0]       step,
    output logic             step_strobe
);

    state_t           state_reg, state_next;
    logic [2:0]       step_reg, step_next;
    logic [PER_W-1:0] cnt_reg, cnt_next;
    logic             strobe_reg, strobe_next;
    logic [5:0]       gates_reg, gates_next;

    logic             pwm_on;
    logic             go_idle;
    logic             advance;
    logic [5:0]       pattern;
    logic [5:0]       drive;

`ifdef BLDC_COMMUTATOR_DEADTIME_EN
    localparam int               DEAD_W    = $clog2(DEAD_CYC) + 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);
    logic [DEAD_W-1:0] dead_cnt_reg, dead_cnt_next;
`endif

    bldc_pwm_gen #(
        .PWM_W (PWM_W)
    ) u_pwm (
        .clk    (clk),
        .reset  (reset),
        .duty   (duty),
        .pwm_on (pwm_on)
    );

    assign pattern = gate_pattern(step_reg);

    // High-side bits follow the PWM, low-side bits stay on for the whole step.
    for (genvar gi = 0; gi < 6; gi++) begin : g_drive
        assign drive[gi] = pattern[gi] & (HIGH_MASK[gi] ? pwm_on : 1'b1);
    end

    assign go_idle = !enable || (step_period == '0);
    assign advance = (cnt_reg >= step_period - PER_W'(1));

    always_comb begin
        state_next  = state_reg;
        step_next   = step_reg;
        cnt_next    = cnt_reg;
        strobe_next = 1'b0;
`ifdef BLDC_COMMUTATOR_DEADTIME_EN
        dead_cnt_next = dead_cnt_reg;
`endif
        // Stopping wins over any advance due in the same cycle.
        if (go_idle) begin
            state_next = ST_IDLE;
            step_next  = STEP_IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next  = ST_RUN;
                    step_next   = dir ? STEP_6 : STEP_1;
                    strobe_next = 1'b1;
                    cnt_next    = '0;
                end
                ST_RUN, ST_DEAD: begin
                    if (advance) begin
                        cnt_next    = '0;
                        step_next   = next_step(step_reg, dir);
                        strobe_next = 1'b1;
`ifdef BLDC_COMMUTATOR_DEADTIME_EN
                        state_next    = ST_DEAD;
                        dead_cnt_next = '0;
`endif
                    end else begin
                        cnt_next = cnt_reg + PER_W'(1);
`ifdef BLDC_COMMUTATOR_DEADTIME_EN
                        if (state_reg == ST_DEAD) begin
                            if (dead_cnt_reg == DEAD_LAST) begin
                                state_next = ST_RUN;
                            end else begin
                                dead_cnt_next = dead_cnt_reg + DEAD_W'(1);
                            end
                        end
`endif
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    step_next  = STEP_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Gates lag the step register by one cycle; DEAD and IDLE force all off.
    always_comb begin
        gates_next = GATES_OFF;
        if (!go_idle && (state_reg == ST_RUN)) begin
            gates_next = drive;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            step_reg   <= STEP_IDLE;
            cnt_reg    <= '0;
            strobe_reg <= 1'b0;
            gates_reg  <= GATES_OFF;
        end else begin
            state_reg  <= state_next;
            step_reg   <= step_next;
            cnt_reg    <= cnt_next;
            strobe_reg <= strobe_next;
            gates_reg  <= gates_next;
        end
    end

`ifdef BLDC_COMMUTATOR_DEADTIME_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            dead_cnt_reg <= '0;
        end else begin
            dead_cnt_reg <= dead_cnt_next;
        end
    end
`endif

    assign {u_up, u_down, v_up, v_down, w_up, w_down} = gates_reg;
    assign step        = step_reg;
    assign step_strobe = strobe_reg;

endmodule

// File: tb/tb_bldc_commutator.sv
// Scoreboard bench for bldc_commutator: stimulus queues expected step strobes,
// a negedge monitor pops and checks step, spacing, gate pattern and overlap.
module tb_bldc_commutator;

    localparam int PER_W    = 32;
    localparam int PWM_W    = 8;
    localparam int DEAD_CYC = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             dir = 1'b0;
    logic [PER_W-1:0] step_period = '0;
    logic [PWM_W-1:0] duty = '0;
    logic             u_up, u_down, v_up, v_down, w_up, w_down;
    logic [2:0]       step;
    logic             step_strobe;
    logic [5:0]       gates;

    always #5 clk = ~clk;

    bldc_commutator #(
        .PER_W    (PER_W),
        .PWM_W    (PWM_W),
        .DEAD_CYC (DEAD_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .dir         (dir),
        .step_period (step_period),
        .duty        (duty),
        .u_up        (u_up),
        .u_down      (u_down),
        .v_up        (v_up),
        .v_down      (v_down),
        .w_up        (w_up),
        .w_down      (w_down),
        .step        (step),
        .step_strobe (step_strobe)
    );

    assign gates = {u_up, u_down, v_up, v_down, w_up, w_down};

    typedef struct {
        logic [2:0] stp;
        int         gap;
        logic       entry;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   overlap_errs = 0;
    int   cyc = 0;
    int   last_strobe = 0;
    logic pend = 1'b0;
    logic [2:0] pend_step = 3'd0;

    // Hand-written commutation table {u_up,u_down,v_up,v_down,w_up,w_down}.
    function automatic logic [5:0] ref_gates(input logic [2:0] s);
        case (s)
            3'd1:    return 6'b100001;
            3'd2:    return 6'b100100;
            3'd3:    return 6'b000110;
            3'd4:    return 6'b010010;
            3'd5:    return 6'b011000;
            3'd6:    return 6'b001001;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endfunction

    task automatic push(input logic [2:0] s, input int g);
        exp_t e;
        e.stp   = s;
        e.gap   = g;
        e.entry = (g == 0);
        exp_q.push_back(e);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_idle(input string name);
        check({name, "_step"}, int'(step), 0);
        check({name, "_gates"}, int'(gates), 0);
        check({name, "_strobe"}, int'(step_strobe), 0);
    endtask

    // Monitor: invariant every cycle, scoreboard pop on every strobe.
    always @(negedge clk) begin
        logic [5:0] p;
        exp_t e;
        cyc++;
        if ((u_up && u_down) || (v_up && v_down) || (w_up && w_down)) overlap_errs++;
        if (pend) begin
            pend = 1'b0;
            p = ref_gates(pend_step);
            check("gates_low", int'(gates & 6'b010101), int'(p & 6'b010101));
            check("gates_high_extra", int'(gates & 6'b101010 & ~p), 0);
        end
        if (step_strobe) begin
            check("strobe_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("strobe cycle=%0d step=%0d expect=%0d gap=%0d", cyc, step, e.stp, cyc - last_strobe);
                check("strobe_step", int'(step), int'(e.stp));
                if (e.gap > 0) check("strobe_gap", cyc - last_strobe, e.gap);
`ifdef BLDC_COMMUTATOR_DEADTIME_EN
                pend = e.entry;
`else
                pend = 1'b1;
`endif
                pend_step = e.stp;
            end
            last_strobe = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_a;
        int cnt_b;

        // Reset state.
        repeat (3) @(negedge clk);
        check_idle("reset");

        // Forward run, period 10, full duty: 1..6 then wrap to 1.
        push(3'd1, 0);
        for (int s = 2; s <= 6; s++) push(3'(s), 10);
        push(3'd1, 10);
        sync();
        reset = 1'b0; enable = 1'b1; dir = 1'b0; step_period = 10; duty = 8'd255;
        wait_drain(100);
        #1 enable = 1'b0;
        @(posedge clk); @(negedge clk);
        check_idle("disable");

        // Reverse run, period 4, then dir flip while in step 3.
        sync();
        push(3'd6, 0); push(3'd5, 4); push(3'd4, 4); push(3'd3, 4);
        enable = 1'b1; dir = 1'b1; step_period = 4;
        wait_drain(40);
        #1 dir = 1'b0;
        push(3'd4, 4); push(3'd5, 4);
        wait_drain(20);
        #1 enable = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rev_idle_step", int'(step), 0);

        // PWM duty on the step-1 high side, low side held.
        sync();
        push(3'd1, 0);
        enable = 1'b1; step_period = 1000; duty = 8'd64;
        wait_drain(10);
        cnt_a = 0; cnt_b = 0;
        repeat (256) begin
            @(negedge clk);
            cnt_a += int'(u_up);
            cnt_b += int'(w_down);
        end
        check("pwm64_u_up", cnt_a, 64);
        check("pwm64_w_down", cnt_b, 256);
        sync(); duty = 8'd0;
        repeat (2) @(posedge clk);
        cnt_a = 0;
        repeat (256) begin @(negedge clk); cnt_a += int'(u_up); end
        check("pwm0_u_up", cnt_a, 0);
        sync(); duty = 8'd255;
        repeat (2) @(posedge clk);
        cnt_a = 0;
        repeat (256) begin @(negedge clk); cnt_a += int'(u_up); end
        check("pwm255_u_up", cnt_a, 255);
        sync(); enable = 1'b0;
        @(posedge clk); @(negedge clk);
        check("pwm_idle_gates", int'(gates), 0);

        // Shrink period below the running count, then write zero.
        sync();
        push(3'd1, 0);
        enable = 1'b1; step_period = 100;
        wait_drain(10);
        repeat (49) @(posedge clk);
        #1;
        push(3'd2, 51); push(3'd3, 20); push(3'd4, 20);
        step_period = 20;
        wait_drain(100);
        #1 step_period = 0;
        @(posedge clk); @(negedge clk);
        check("period0_step", int'(step), 0);
        check("period0_gates", int'(gates), 0);

        // Reset asserted mid-step 4 with enable held high.
        sync();
        push(3'd1, 0);
        for (int s = 2; s <= 4; s++) push(3'(s), 10);
        step_period = 10;
        wait_drain(60);
        #1 reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check_idle("midreset");
        push(3'd1, 0);
        sync(); reset = 1'b0;
        wait_drain(10);
        check("reentry_step", int'(step), 1);
        sync(); enable = 1'b0;
        repeat (3) @(negedge clk);

`ifdef BLDC_COMMUTATOR_DEADTIME_EN
        // Dead time: 16 off cycles after an advance, then 84 of the new pattern.
        sync();
        push(3'd1, 0); push(3'd2, 100);
        enable = 1'b1; step_period = 100; duty = 8'd255;
        wait_drain(220);
        push(3'd3, 100);
        cnt_a = 0; cnt_b = 0;
        repeat (16) begin @(negedge clk); cnt_a += int'(gates == 6'b0); end
        repeat (84) begin @(negedge clk); cnt_b += int'(v_down); end
        check("dead_off_cycles", cnt_a, 16);
        check("dead_on_cycles", cnt_b, 84);
        wait_drain(10);
        sync();
        push(3'd4, -1); push(3'd5, -1); push(3'd6, -1); push(3'd1, -1);
        step_period = 10;
        cnt_a = 0;
        for (int n = 0; n < 80 && exp_q.size() != 0; n++) begin
            @(negedge clk);
            cnt_a += int'(gates != 6'b0);
        end
        check("dead_short_period_on", cnt_a, 0);
        wait_drain(5);
        sync(); enable = 1'b0;
        repeat (3) @(negedge clk);
`endif

        check("overlap_cycles", overlap_errs, 0);
        check("queue_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
